parity_check_arbiter: RTL and testbench
=======================================

# parity_check_arbiter

Shares one even-parity check datapath between two requesters. Each requester offers an 8-bit word plus a parity bit. A round-robin arbiter grants one transaction at a time, and a small FSM sequences capture, check and response. A saturating error counter accumulates failed checks. The block sits between byte producers and downstream error handling.

## Interface
Parameters:
- `CNT_W`, default 8: width of the saturating error counter.

Ports (name, direction, width, meaning):
- `clk`, in, 1: single clock; all logic on the rising edge.
- `rst`, in, 1: synchronous, active-high reset.
- `req0_valid`, in, 1: requester 0 offers a word.
- `req0_data`, in, 8: requester 0 data word.
- `req0_parity`, in, 1: requester 0 even-parity bit.
- `req0_ready`, out, 1: requester 0 transaction accepted this cycle.
- `req1_valid`, `req1_data`, `req1_parity`, `req1_ready`: same as requester 0, for requester 1.
- `resp_valid`, out, 1: result available.
- `resp_id`, out, 1: requester that owns the result (0 or 1).
- `resp_error`, out, 1: 1 when `data` plus `parity` has an odd number of ones.
- `resp_ready`, in, 1: consumer accepts the result.
- `err_count`, out, `CNT_W`: number of checks with `resp_error=1`, saturating.
- `err_clear`, in, 1: synchronous clear of `err_count`.

## Operation
- FSM states: IDLE, CHECK, RESP.
- IDLE:
  - Arbitrate among asserted `reqN_valid` signals. When both are asserted, the requester named by the priority pointer `prio` wins.
  - Assert `reqN_ready` combinationally for the winner only, and only in IDLE.
  - On handshake (`valid & ready`), capture data, parity and id, then go to CHECK.
  - `prio` becomes the non-winner. It changes only on a grant.
- CHECK:
  - Compute `error = ^{data, parity}` into a result register.
  - Go to RESP unconditionally.
- RESP:
  - Hold `resp_valid=1`, with `resp_id` and `resp_error` stable.
  - On `resp_valid & resp_ready`, return to IDLE.
  - No request is accepted in the same cycle as the response handshake.
- Error counter:
  - Increments by 1 on the response handshake when `resp_error=1`.
  - Saturates at 2^CNT_W-1.
  - `err_clear` takes priority over increment; the counter is 0 on the next cycle.
- Invalid requests: request data is ignored whenever `reqN_valid=0`. No ready is issued outside IDLE.
- Reset mid-transaction: an in-flight capture or pending response is discarded silently and is not counted.

## Timing
- Reset values: state=IDLE, `prio`=0, `req0_ready`=0, `req1_ready`=0, `resp_valid`=0, `resp_id`=0, `resp_error`=0, `err_count`=0.
- Latency: accept at edge N, CHECK during cycle N+1, `resp_valid=1` from cycle N+2.
- Minimum period of 3 cycles per transaction, reached when `resp_ready` is tied high.
- Backpressure: `resp_valid` stays high and the outputs stay stable indefinitely until `resp_ready` is seen.
- Ready is combinational from valid and state. It must not depend on `resp_ready`.
- Simultaneous `err_clear` and an error response handshake: the counter ends at 0; that error is not counted.
- Saturation: at the maximum value a further error leaves the counter unchanged (no wrap).

## Test plan
- **Reset:** hold `rst` for 2 cycles with all inputs random. All outputs are at their reset values, and no ready is asserted during reset.
- **Single check, requester 0, `resp_ready=1`:**
  - `data=8'h00`, `parity=1`: `resp_error=1`, `resp_id=0`, exactly 2 cycles after accept.
  - `data=8'h03`, `parity=0`: `resp_error=0`.
- **Contention:** both valid continuously, with the data sequence `8'h01/0`, `8'h80/1`, `8'h55/0`, `8'hAA/1`.
  - Grants alternate 0,1,0,1, starting with requester 0 after reset.
  - Each requester gets exactly one grant per 6 cycles.
- **Backpressure:** hold `resp_ready=0` for 5 cycles in RESP.
  - `resp_valid` and `resp_error` stay stable.
  - Both `reqN_ready` stay 0.
  - The transaction completes 1 cycle after `resp_ready` rises, and the next grant follows on the cycle after that.
- **Counter:** with `CNT_W=2`, run 5 erroring checks; `err_count` ends at 3. Then assert `err_clear` in the same cycle as a sixth erroring handshake; `err_count=0`.
- **Reset mid-operation:** assert `rst` while in CHECK. No `resp_valid` appears, `err_count` is unchanged at 0, and the next request is accepted normally.

Source files
------------

// File: rtl/parity_check_arbiter.sv
// Round-robin arbiter sharing one even-parity checker between two byte requesters.
// Transactions step IDLE -> CHECK -> RESP and erroring results feed a saturating counter.
module parity_check_arbiter #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req0_valid,
    input  logic [7:0]       req0_data,
    input  logic             req0_parity,
    output logic             req0_ready,
    input  logic             req1_valid,
    input  logic [7:0]       req1_data,
    input  logic             req1_parity,
    output logic             req1_ready,
    output logic             resp_valid,
    output logic             resp_id,
    output logic             resp_error,
    input  logic             resp_ready,
    output logic [CNT_W-1:0] err_count,
    input  logic             err_clear
);

    typedef enum logic [1:0] {
        IDLE,
        CHECK,
        RESP
    } state_t;

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    state_t     state;
    logic       prio;
    logic [7:0] cap_data;
    logic       cap_parity;
    logic       cap_id;
    logic       grant0;
    logic       grant1;
    logic       resp_fire;

    // Grants are held low during reset so no requester sees a spurious ready.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!rst && state == IDLE) begin
            if (req0_valid && (!req1_valid || !prio)) begin
                grant0 = 1'b1;
            end else if (req1_valid) begin
                grant1 = 1'b1;
            end
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign resp_fire  = resp_valid && resp_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            prio       <= 1'b0;
            cap_data   <= 8'h00;
            cap_parity <= 1'b0;
            cap_id     <= 1'b0;
            resp_valid <= 1'b0;
            resp_id    <= 1'b0;
            resp_error <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (grant0 || grant1) begin
                        cap_data   <= grant0 ? req0_data : req1_data;
                        cap_parity <= grant0 ? req0_parity : req1_parity;
                        cap_id     <= grant1;
                        prio       <= grant0;
                        state      <= CHECK;
                    end
                end
                CHECK: begin
                    resp_error <= ^{cap_data, cap_parity};
                    resp_id    <= cap_id;
                    resp_valid <= 1'b1;
                    state      <= RESP;
                end
                RESP: begin
                    if (resp_ready) begin
                        resp_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // A clear wins over a same-cycle erroring handshake, so that error is dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            err_count <= '0;
        end else if (err_clear) begin
            err_count <= '0;
        end else if (resp_fire && resp_error && err_count != CNT_MAX) begin
            err_count <= err_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_parity_check_arbiter.sv
// Directed scoreboard bench for parity_check_arbiter built with a 2-bit error counter.
module tb_parity_check_arbiter;

    localparam int CNT_W = 2;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             req0_valid = 1'b0;
    logic [7:0]       req0_data = 8'h00;
    logic             req0_parity = 1'b0;
    logic             req0_ready;
    logic             req1_valid = 1'b0;
    logic [7:0]       req1_data = 8'h00;
    logic             req1_parity = 1'b0;
    logic             req1_ready;
    logic             resp_valid;
    logic             resp_id;
    logic             resp_error;
    logic             resp_ready = 1'b1;
    logic [CNT_W-1:0] err_count;
    logic             err_clear = 1'b0;

    int compared = 0;
    int mismatched = 0;

    logic [1:0]       sb[$];
    logic             model_prio;
    logic [CNT_W-1:0] model_cnt;

    parity_check_arbiter #(.CNT_W(CNT_W)) dut (
        .clk(clk),
        .rst(rst),
        .req0_valid(req0_valid),
        .req0_data(req0_data),
        .req0_parity(req0_parity),
        .req0_ready(req0_ready),
        .req1_valid(req1_valid),
        .req1_data(req1_data),
        .req1_parity(req1_parity),
        .req1_ready(req1_ready),
        .resp_valid(resp_valid),
        .resp_id(resp_id),
        .resp_error(resp_error),
        .resp_ready(resp_ready),
        .err_count(err_count),
        .err_clear(err_clear)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input logic v0, input logic [7:0] d0, input logic p0,
                                 input logic v1, input logic [7:0] d1, input logic p1);
        req0_valid  = v0;
        req0_data   = d0;
        req0_parity = p0;
        req1_valid  = v1;
        req1_data   = d1;
        req1_parity = p1;
    endtask

    // Holds reset for two cycles with random inputs, then releases it just after an edge.
    task automatic doReset();
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            applyStimulus(1'($urandom), 8'($urandom), 1'($urandom),
                          1'($urandom), 8'($urandom), 1'($urandom));
            resp_ready = 1'($urandom);
            err_clear  = 1'($urandom);
            @(posedge clk);
            #1;
            checkOutput("rst_req0_ready", req0_ready, 0);
            checkOutput("rst_req1_ready", req1_ready, 0);
            checkOutput("rst_resp_valid", resp_valid, 0);
            checkOutput("rst_resp_id", resp_id, 0);
            checkOutput("rst_resp_error", resp_error, 0);
            checkOutput("rst_err_count", err_count, 0);
        end
        rst = 1'b0;
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        resp_ready = 1'b1;
        err_clear  = 1'b0;
        model_prio = 1'b0;
        model_cnt  = '0;
        sb.delete();
    endtask

    // One transaction: called just after an edge in IDLE, returns just after the response handshake.
    task automatic runTxn(input logic v0, input logic [7:0] d0, input logic p0,
                          input logic v1, input logic [7:0] d1, input logic p1,
                          input int stall, input logic clr);
        logic       win;
        logic [1:0] exp;
        logic [1:0] got;
        applyStimulus(v0, d0, p0, v1, d1, p1);
        resp_ready = 1'b1;
        err_clear  = 1'b0;
        win = (v0 && (!v1 || !model_prio)) ? 1'b0 : 1'b1;
        exp = {win, win ? ^{d1, p1} : ^{d0, p0}};
        sb.push_back(exp);
        @(negedge clk);
        checkOutput("grant_req0_ready", req0_ready, !win);
        checkOutput("grant_req1_ready", req1_ready, win);
        @(posedge clk);
        model_prio = !win;
        #1;
        resp_ready = 1'b1;
        @(negedge clk);
        checkOutput("check_req0_ready", req0_ready, 0);
        checkOutput("check_req1_ready", req1_ready, 0);
        checkOutput("check_resp_valid", resp_valid, 0);
        @(posedge clk);
        #1;
        resp_ready = (stall == 0);
        err_clear  = clr && (stall == 0);
        @(negedge clk);
        checkOutput("sb_nonempty", sb.size() != 0, 1);
        got = (sb.size() != 0) ? sb.pop_front() : 2'bxx;
        checkOutput("resp_valid", resp_valid, 1);
        checkOutput("resp_id", resp_id, got[1]);
        checkOutput("resp_error", resp_error, got[0]);
        for (int i = 1; i <= stall; i++) begin
            @(posedge clk);
            #1;
            if (i == stall) begin
                resp_ready = 1'b1;
                err_clear  = clr;
            end
            @(negedge clk);
            checkOutput("stall_resp_valid", resp_valid, 1);
            checkOutput("stall_resp_id", resp_id, got[1]);
            checkOutput("stall_resp_error", resp_error, got[0]);
            checkOutput("stall_req0_ready", req0_ready, 0);
            checkOutput("stall_req1_ready", req1_ready, 0);
        end
        @(posedge clk);
        if (clr) model_cnt = '0;
        else if (got[0] && model_cnt != CNT_MAX) model_cnt = model_cnt + CNT_W'(1);
        #1;
        err_clear = 1'b0;
        checkOutput("done_resp_valid", resp_valid, 0);
        checkOutput("done_err_count", err_count, model_cnt);
    endtask

    initial begin
        logic [8:0] seq[4];
        seq[0] = {8'h01, 1'b0};
        seq[1] = {8'h80, 1'b1};
        seq[2] = {8'h55, 1'b0};
        seq[3] = {8'hAA, 1'b1};

        $display("[TB] reset");
        doReset();

        $display("[TB] single checks on requester 0");
        runTxn(1'b1, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 0, 1'b0);
        runTxn(1'b1, 8'h03, 1'b0, 1'b0, 8'h00, 1'b0, 0, 1'b0);

        $display("[TB] contention");
        doReset();
        for (int i = 0; i < 4; i++) begin
            runTxn(1'b1, seq[i][8:1], seq[i][0], 1'b1, seq[i][8:1], !seq[i][0], 0, 1'b0);
        end

        $display("[TB] backpressure");
        runTxn(1'b0, 8'h00, 1'b0, 1'b1, 8'h07, 1'b0, 5, 1'b0);
        runTxn(1'b1, 8'h0F, 1'b1, 1'b1, 8'h0F, 1'b0, 0, 1'b0);

        $display("[TB] counter saturation and clear");
        doReset();
        for (int i = 0; i < 5; i++) begin
            runTxn(1'b1, 8'h01, 1'b0, 1'b0, 8'h00, 1'b0, 0, 1'b0);
        end
        runTxn(1'b1, 8'h01, 1'b0, 1'b0, 8'h00, 1'b0, 0, 1'b1);

        $display("[TB] reset mid-operation");
        applyStimulus(1'b1, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0);
        @(negedge clk);
        checkOutput("midrst_grant", req0_ready, 1);
        @(posedge clk);
        #1;
        applyStimulus(1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_prio = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("midrst_resp_valid", resp_valid, 0);
            checkOutput("midrst_err_count", err_count, 0);
            @(posedge clk);
            #1;
        end
        runTxn(1'b1, 8'h01, 1'b0, 1'b1, 8'h03, 1'b0, 0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
